// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl
//   Raster timing generator for a DVI/TMDS transmitter. Walks the pixel
//   position across a frame of (H_ACTIVE+H_FP+H_SYNC+H_BP) x
//   (V_ACTIVE+V_FP+V_SYNC+V_BP) cycles and produces data enable, syncs and
//   the position itself, all registered and aligned to the same cycle.
//   A frame, once started, is always completed; dropping en_i only stops
//   the generator at the next frame boundary.
//
// Ports
//   clk_i          pixel clock (single clock domain)
//   rst_i          synchronous active-high reset, wins over en_i
//   en_i           run request, level-sensitive
//   de_o           data enable to the TMDS encoders
//   hsync_o        horizontal sync (blue-channel C0), polarity H_POL
//   vsync_o        vertical sync (blue-channel C1), polarity V_POL
//   x_o, y_o       position shown in the current cycle
//   frame_start_o  one-cycle pulse on cycles showing (0,0)
//   busy_o         high on every cycle that shows a position
module dvi_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic        frame_start_o,
  output logic        busy_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || H_TOTAL < 1) begin : g_h_total_check
    $error("dvi_timing_ctrl: H_TOTAL must be in 1..4096");
  end
  if (V_TOTAL > 4096 || V_TOTAL < 1) begin : g_v_total_check
    $error("dvi_timing_ctrl: V_TOTAL must be in 1..4096");
  end

  // 13-bit thresholds so that a value of exactly 4096 still fits.
  localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] H_LAST     = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] V_LAST     = 13'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  state_t      state_p0;
  state_t      state_d;
  logic [11:0] x_p0;
  logic [11:0] y_p0;
  logic [11:0] x_d;
  logic [11:0] y_d;
  logic        x_wrap;
  logic        y_wrap;
  logic        active_d;

  logic        de_p0;
  logic        hs_p0;
  logic        vs_p0;
  logic        fs_p0;
  logic        vld_p0;

  // Half-open window test lo <= v < hi on zero-extended positions.
  function automatic logic in_win(input logic [11:0] v,
                                  input logic [12:0] lo,
                                  input logic [12:0] hi);
    logic [12:0] ve;
    ve = {1'b0, v};
    return (ve >= lo) && (ve < hi);
  endfunction

  function automatic logic below(input logic [11:0] v, input logic [12:0] lim);
    return {1'b0, v} < lim;
  endfunction

  // Next state / next position. The output registers below are loaded from
  // these next values so that every output describes the position held in
  // x_p0/y_p0 during the same cycle.
  always_comb begin
    state_d = state_p0;
    x_d     = x_p0;
    y_d     = y_p0;
    x_wrap  = ({1'b0, x_p0} == H_LAST);
    y_wrap  = ({1'b0, y_p0} == V_LAST);

    if (rst_i) begin
      state_d = S_IDLE;
      x_d     = 12'd0;
      y_d     = 12'd0;
    end else begin
      case (state_p0)
        S_IDLE: begin
          x_d = 12'd0;
          y_d = 12'd0;
          if (en_i) begin
            state_d = S_RUN;
          end
        end
        S_RUN, S_STOPPING: begin
          if (x_wrap && y_wrap && !en_i) begin
            // Frame complete and no run request: stop on the boundary.
            state_d = S_IDLE;
            x_d     = 12'd0;
            y_d     = 12'd0;
          end else begin
            state_d = en_i ? S_RUN : S_STOPPING;
            if (x_wrap) begin
              x_d = 12'd0;
              y_d = y_wrap ? 12'd0 : (y_p0 + 12'd1);
            end else begin
              x_d = x_p0 + 12'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          x_d     = 12'd0;
          y_d     = 12'd0;
        end
      endcase
    end

    active_d = (state_d != S_IDLE);
  end

  // ---- stage p0: state and position registers ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p0 <= S_IDLE;
      x_p0     <= 12'd0;
      y_p0     <= 12'd0;
    end else begin
      state_p0 <= state_d;
      x_p0     <= x_d;
      y_p0     <= y_d;
    end
  end

  // ---- stage p0: decoded outputs, aligned with x_p0/y_p0 ----
  always_ff @(posedge clk_i) begin
    vld_p0 <= active_d;
    de_p0  <= active_d && below(x_d, H_ACT_END) && below(y_d, V_ACT_END);
    hs_p0  <= (active_d && in_win(x_d, H_SYNC_BEG, H_SYNC_END)) ? H_POL : ~H_POL;
    vs_p0  <= (active_d && in_win(y_d, V_SYNC_BEG, V_SYNC_END)) ? V_POL : ~V_POL;
    fs_p0  <= active_d && (x_d == 12'd0) && (y_d == 12'd0);
  end

  assign de_o          = de_p0;
  assign hsync_o       = hs_p0;
  assign vsync_o       = vs_p0;
  assign x_o           = x_p0;
  assign y_o           = y_p0;
  assign frame_start_o = fs_p0;
  assign busy_o        = vld_p0;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Bench for dvi_timing_ctrl with an 8 x 6 raster (H 4/1/2/1, V 3/1/1/1,
// active-low syncs). A table of {rst, en, expected outputs} vectors covers
// reset, three back-to-back frames and a stop on the frame boundary; the
// hand-written sequences cover early stop, stop/restart, mid-frame reset and
// re-raising en_i exactly on the last position.
module tb_dvi_timing_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        de;
  logic        hs;
  logic        vs;
  logic [11:0] x;
  logic [11:0] y;
  logic        fs;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cur_x    = 0;
  int cur_y    = 0;

  dvi_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .de_o         (de),
    .hsync_o      (hs),
    .vsync_o      (vs),
    .x_o          (x),
    .y_o          (y),
    .frame_start_o(fs),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit en;
    bit busy;
    int x;
    int y;
    bit de;
    bit hs;
    bit vs;
    bit fs;
  } vec_t;

  vec_t vecs[160];
  int   n_vec;

  // Expected outputs for a cycle showing (px,py) (act=1) or an IDLE cycle.
  function automatic vec_t mk(input bit r, input bit e, input bit act,
                              input int px, input int py);
    vec_t v;
    v.rst  = r;
    v.en   = e;
    v.busy = act;
    v.x    = act ? px : 0;
    v.y    = act ? py : 0;
    v.de   = act && (px < 4) && (py < 3);
    v.hs   = !(act && (px == 5 || px == 6));
    v.vs   = !(act && (py == 4));
    v.fs   = act && (px == 0) && (py == 0);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " busy"}, int'(busy), int'(v.busy));
    chk({tag, " x"},    int'(x),    v.x);
    chk({tag, " y"},    int'(y),    v.y);
    chk({tag, " de"},   int'(de),   int'(v.de));
    chk({tag, " hs"},   int'(hs),   int'(v.hs));
    chk({tag, " vs"},   int'(vs),   int'(v.vs));
    chk({tag, " fs"},   int'(fs),   int'(v.fs));
  endtask

  task automatic apply(input bit r, input bit e);
    rst = r;
    en  = e;
    @(posedge clk);
    #1;
  endtask

  // Step to the next raster position with en_i = e, checking every cycle.
  task automatic adv(input string tag, input bit e, input int n);
    for (int i = 0; i < n; i++) begin
      if (cur_x == 7) begin
        cur_x = 0;
        cur_y = (cur_y == 5) ? 0 : cur_y + 1;
      end else begin
        cur_x = cur_x + 1;
      end
      apply(1'b0, e);
      check_vec($sformatf("%s (%0d,%0d)", tag, cur_x, cur_y),
                mk(1'b0, e, 1'b1, cur_x, cur_y));
    end
  endtask

  task automatic start(input string tag);
    apply(1'b0, 1'b1);
    cur_x = 0;
    cur_y = 0;
    check_vec({tag, " start"}, mk(1'b0, 1'b1, 1'b1, 0, 0));
  endtask

  task automatic idle(input string tag, input bit r, input bit e);
    apply(r, e);
    check_vec(tag, mk(r, e, 1'b0, 0, 0));
  endtask

  int de_cnt;
  int fs_cnt;
  int last_fs;

  initial begin
    rst = 1'b1;
    en  = 1'b0;

    // Table: reset, reset-over-enable, idle, 3 continuous frames, then en_i
    // dropped while (7,5) is shown in RUN, which ends directly in IDLE.
    n_vec = 0;
    vecs[n_vec++] = mk(1'b1, 1'b0, 1'b0, 0, 0);
    vecs[n_vec++] = mk(1'b1, 1'b1, 1'b0, 0, 0);
    vecs[n_vec++] = mk(1'b0, 1'b0, 1'b0, 0, 0);
    for (int f = 0; f < 3; f++)
      for (int py = 0; py < 6; py++)
        for (int px = 0; px < 8; px++)
          vecs[n_vec++] = mk(1'b0, 1'b1, 1'b1, px, py);
    vecs[n_vec++] = mk(1'b0, 1'b0, 1'b0, 0, 0);
    vecs[n_vec++] = mk(1'b0, 1'b0, 1'b0, 0, 0);

    de_cnt  = 0;
    fs_cnt  = 0;
    last_fs = -1;
    for (int i = 0; i < n_vec; i++) begin
      apply(vecs[i].rst, vecs[i].en);
      check_vec($sformatf("vec%0d", i), vecs[i]);
      if (de) de_cnt++;
      if (fs) begin
        if (last_fs >= 0) chk($sformatf("fs period vec%0d", i), i - last_fs, 48);
        last_fs = i;
        fs_cnt++;
      end
    end
    chk("table frame_start count", fs_cnt, 3);
    chk("table de count", de_cnt, 36);

    // En dropped at (2,1): frame completes to (7,5), then IDLE for good.
    start("s3");
    adv("s3 run", 1'b1, 10);
    adv("s3 stop", 1'b0, 37);
    for (int i = 0; i < 4; i++) idle($sformatf("s3 idle%0d", i), 1'b0, 1'b0);

    // En dropped at (2,1), re-raised at (3,3): no break, (0,0) follows (7,5).
    start("s4");
    adv("s4 run", 1'b1, 10);
    adv("s4 stop", 1'b0, 17);
    adv("s4 rerun", 1'b1, 21);

    // Reset at (3,2): IDLE next cycle, then (0,0) right after release.
    adv("s5 run", 1'b1, 19);
    idle("s5 rst", 1'b1, 1'b1);
    start("s5");
    adv("s5 run2", 1'b1, 1);

    // Stopping, en_i re-raised exactly while (7,5) is shown: wraps to (0,0).
    adv("s7 stop", 1'b0, 46);
    adv("s7 last", 1'b1, 1);
    adv("s7 stop2", 1'b0, 47);
    idle("s7 idle", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dvi_timing_ctrl.md
DVI_TIMING_CTRL -- requirements
Module: dvi_timing_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front-porch cycles.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse cycles.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back-porch cycles.
REQ-005 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front-porch lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back-porch lines.
REQ-009 SHALL have parameter H_POL, default 0, hsync asserted level (0 = active-low).
REQ-010 SHALL have parameter V_POL, default 0, vsync asserted level (0 = active-low).
REQ-011 SHALL have port clk_i, input, 1, pixel clock; the block has exactly one clock.
REQ-012 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-013 SHALL have port en_i, input, 1, run request, level-sensitive.
REQ-014 SHALL have port de_o, output, 1, data enable to the TMDS encoders.
REQ-015 SHALL have port hsync_o, output, 1, horizontal sync, drives blue-channel C0.
REQ-016 SHALL have port vsync_o, output, 1, vertical sync, drives blue-channel C1.
REQ-017 SHALL have port x_o, output, 12, horizontal position of the current cycle.
REQ-018 SHALL have port y_o, output, 12, vertical position of the current cycle.
REQ-019 SHALL have port frame_start_o, output, 1, single-cycle pulse at position (0,0).
REQ-020 SHALL have port busy_o, output, 1, high while in RUN or STOPPING.

Function
REQ-021 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = the V equivalent; both SHALL be at most 4096, with elaboration failing otherwise.
REQ-022 FSM states: IDLE, RUN, STOPPING.
REQ-023 IDLE -> RUN at the edge where en_i=1 is sampled; the next cycle outputs position (0,0).
REQ-024 RUN -> STOPPING at the edge where en_i=0 is sampled; STOPPING -> RUN if en_i=1 is sampled before frame end.
REQ-025 STOPPING SHALL complete the frame; at the last position (H_TOTAL-1, V_TOTAL-1) it goes to IDLE, with no partial frames.
REQ-026 RUN with en_i=1 at (H_TOTAL-1, V_TOTAL-1) SHALL wrap to (0,0) on the next cycle, with no gap cycle.
REQ-027 Position x SHALL increment each RUN/STOPPING cycle; at x=H_TOTAL-1 it wraps to 0 and y increments; at y=V_TOTAL-1 with x wrapping, y wraps to 0.
REQ-028 de_o=1 iff x<H_ACTIVE and y<V_ACTIVE, while in RUN/STOPPING.
REQ-029 hsync_o=H_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
REQ-030 vsync_o=V_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for the whole line regardless of x; otherwise ~V_POL.
REQ-031 All outputs SHALL be registered and mutually aligned: de_o, syncs, x_o, y_o and frame_start_o in a given cycle describe the same position.
REQ-032 frame_start_o SHALL be 1 only on cycles showing (0,0), including after wrap and after IDLE->RUN.
REQ-033 In IDLE: de_o=0, hsync_o=~H_POL, vsync_o=~V_POL, x_o=0, y_o=0, frame_start_o=0, busy_o=0.
REQ-034 busy_o SHALL be 1 on every cycle showing a position, and 0 from the cycle after the last STOPPING position.

Reset
REQ-035 rst_i sampled high SHALL force IDLE and the REQ-033 output values on the next cycle, and SHALL take priority over en_i.
REQ-036 Reset mid-frame SHALL abort the frame immediately; after rst_i deasserts with en_i=1, the next frame starts at (0,0).

Verification (use H=4/1/2/1 so H_TOTAL=8, V=3/1/1/1 so V_TOTAL=6, POL=0)
REQ-037 Scenario 1: rst_i then en_i=1 held -> frame_start_o every 48 cycles; de_o high 4 of 8 cycles on y=0..2; 12 de cycles per frame.
REQ-038 Scenario 2: in RUN -> hsync_o=0 exactly at x=5,6; vsync_o=0 for all 8 cycles of y=4; both high elsewhere.
REQ-039 Scenario 3: en_i dropped at position (2,1) -> frame continues to (7,5), then IDLE; busy_o falls the cycle after (7,5); no further frame_start_o.
REQ-040 Scenario 4: en_i dropped at (2,1), re-raised at (3,3) -> no interruption; (0,0) follows (7,5) directly.
REQ-041 Scenario 5: rst_i pulsed at (3,2) -> next cycle shows IDLE values; with en_i=1 the cycle after deassert sampling shows (0,0) with frame_start_o=1.
REQ-042 Scenario 6: en_i=1 held across 3 frames -> x_o/y_o sequence is continuous with wraps at 7 and 5; no glitch cycle at the frame boundary.
